// File: rtl/windowed_rf_pkg.sv
// Shared constants for the windowed register file: logical register regions
// and the window-index wrap helper used by the pointer logic and address map.
package windowed_rf_pkg;

  localparam int unsigned NUM_LOGICAL = 32;
  localparam int unsigned GLOB_BASE   = 0;
  localparam int unsigned GLOB_SIZE   = 8;
  localparam int unsigned OUTS_BASE   = 8;
  localparam int unsigned OUTS_SIZE   = 8;
  localparam int unsigned LOCALS_BASE = 16;
  localparam int unsigned LOCALS_SIZE = 8;
  localparam int unsigned INS_BASE    = 24;
  localparam int unsigned INS_SIZE    = 8;

  // Each window owns outs followed by locals; its ins alias the next window's outs.
  localparam int unsigned OUTS_OFS    = 0;
  localparam int unsigned LOCALS_OFS  = OUTS_SIZE;
  localparam int unsigned WIN_STRIDE  = OUTS_SIZE + LOCALS_SIZE;

  function automatic logic [4:0] win_mod(input int unsigned v, input int unsigned nwin);
    return 5'(v % nwin);
  endfunction

endpackage

// File: rtl/rf_window_map.sv
// Translates a logical register number r0..r31 into either a global index or a
// physical index into the windowed bank, relative to the supplied window pointer.
module rf_window_map
  import windowed_rf_pkg::*;
#(
  parameter int NWIN = 8,
  parameter int PW   = $clog2(NWIN * 16)
) (
  input  logic [4:0]    cwp_i,
  input  logic [4:0]    addr_i,
  output logic          zero_o,
  output logic          global_o,
  output logic [2:0]    glob_idx_o,
  output logic [PW-1:0] win_idx_o
);

  logic [4:0]  win_sel;
  int unsigned ofs;
  int unsigned addr_u;

  assign addr_u     = 32'(addr_i);
  assign zero_o     = (addr_i == '0);
  assign global_o   = (addr_u < GLOB_BASE + GLOB_SIZE);
  assign glob_idx_o = addr_i[2:0];

  always_comb begin
    win_sel = cwp_i;
    ofs     = 0;
    if (addr_u >= INS_BASE) begin
      win_sel = win_mod(32'(cwp_i) + 1, NWIN);
      ofs     = addr_u - INS_BASE + OUTS_OFS;
    end else if (addr_u >= LOCALS_BASE) begin
      ofs     = addr_u - LOCALS_BASE + LOCALS_OFS;
    end else if (addr_u >= OUTS_BASE) begin
      ofs     = addr_u - OUTS_BASE + OUTS_OFS;
    end
  end

  assign win_idx_o = PW'(32'(win_sel) * WIN_STRIDE + ofs);

endmodule

// File: rtl/windowed_register_file.sv
// Register file with 8 globals plus NWIN overlapping 16-register windows,
// a current window pointer with save/restore and overflow/underflow traps.
module windowed_register_file
  import windowed_rf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NWIN   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_a_addr,
  input  logic [4:0]        rd_b_addr,
  output logic [DATA_W-1:0] pa,
  output logic [DATA_W-1:0] pb,
  input  logic              save,
  input  logic              restore,
  input  logic              cwp_we,
  input  logic [4:0]        cwp_wdata,
  input  logic              wim_we,
  input  logic [NWIN-1:0]   wim_wdata,
  output logic [4:0]        cwp,
  output logic [NWIN-1:0]   wim,
  output logic              win_ovf,
  output logic              win_unf
);

  localparam int NPHYS = NWIN * WIN_STRIDE;
  localparam int PW    = $clog2(NPHYS);
  localparam int WI    = $clog2(NWIN);

  logic [DATA_W-1:0] glob_q [GLOB_SIZE];
  logic [DATA_W-1:0] win_q  [NPHYS];

  logic [4:0]      cwp_q, cwp_d;
  logic [NWIN-1:0] wim_q, wim_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [4:0]      cwp_dec, cwp_inc;

  logic          w_zero, w_glob;
  logic [2:0]    w_gidx;
  logic [PW-1:0] w_widx;
  logic          a_zero, a_glob;
  logic [2:0]    a_gidx;
  logic [PW-1:0] a_widx;
  logic          b_zero, b_glob;
  logic [2:0]    b_gidx;
  logic [PW-1:0] b_widx;

  rf_window_map #(.NWIN(NWIN), .PW(PW)) u_map_wr (
    .cwp_i(cwp_q), .addr_i(wr_addr),
    .zero_o(w_zero), .global_o(w_glob), .glob_idx_o(w_gidx), .win_idx_o(w_widx)
  );

  rf_window_map #(.NWIN(NWIN), .PW(PW)) u_map_a (
    .cwp_i(cwp_q), .addr_i(rd_a_addr),
    .zero_o(a_zero), .global_o(a_glob), .glob_idx_o(a_gidx), .win_idx_o(a_widx)
  );

  rf_window_map #(.NWIN(NWIN), .PW(PW)) u_map_b (
    .cwp_i(cwp_q), .addr_i(rd_b_addr),
    .zero_o(b_zero), .global_o(b_glob), .glob_idx_o(b_gidx), .win_idx_o(b_widx)
  );

  // Reads see register contents only; a same-cycle write is visible next cycle.
  assign pa = a_zero ? '0 : (a_glob ? glob_q[a_gidx] : win_q[a_widx]);
  assign pb = b_zero ? '0 : (b_glob ? glob_q[b_gidx] : win_q[b_widx]);

  assign cwp_dec = win_mod(32'(cwp_q) + 32'(NWIN) - 1, NWIN);
  assign cwp_inc = win_mod(32'(cwp_q) + 1, NWIN);

  // Trap checks use the pre-update mask; cwp_we overrides save/restore.
  always_comb begin
    cwp_d = cwp_q;
    wim_d = wim_we ? wim_wdata : wim_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (cwp_we) begin
      cwp_d = win_mod(32'(cwp_wdata), NWIN);
    end else if (save && !restore) begin
      if (wim_q[WI'(cwp_dec)]) ovf_d = 1'b1;
      else                     cwp_d = cwp_dec;
    end else if (restore && !save) begin
      if (wim_q[WI'(cwp_inc)]) unf_d = 1'b1;
      else                     cwp_d = cwp_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cwp_q <= '0;
      wim_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cwp_q <= cwp_d;
      wim_q <= wim_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Write address is decoded with the pre-edge cwp, so a same-edge save/restore
  // does not redirect the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GLOB_SIZE; i++) glob_q[i] <= '0;
      for (int i = 0; i < NPHYS; i++)     win_q[i]  <= '0;
    end else if (wr_en && !w_zero) begin
      if (w_glob) glob_q[w_gidx] <= wr_data;
      else        win_q[w_widx]  <= wr_data;
    end
  end

  assign cwp     = cwp_q;
  assign wim     = wim_q;
  assign win_ovf = ovf_q;
  assign win_unf = unf_q;

endmodule

// File: tb/tb_windowed_register_file.sv
// Self-checking bench: directed window scenarios plus randomized traffic,
// compared every cycle against an array-based model of the register windows.
module tb_windowed_register_file;

  localparam int DW   = 32;
  localparam int NW   = 8;
  localparam int NPH  = NW * 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [4:0]    rd_a_addr, rd_b_addr;
  logic [DW-1:0] pa, pb;
  logic          save, restore, cwp_we, wim_we;
  logic [4:0]    cwp_wdata;
  logic [NW-1:0] wim_wdata;
  logic [4:0]    cwp;
  logic [NW-1:0] wim;
  logic          win_ovf, win_unf;

  int checks = 0;
  int errors = 0;

  // Model state
  int            m_cwp;
  bit [NW-1:0]   m_wim;
  bit            m_ovf, m_unf;
  logic [DW-1:0] m_glob [8];
  logic [DW-1:0] m_phys [NPH];

  windowed_register_file #(.DATA_W(DW), .NWIN(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .pa(pa), .pb(pb),
    .save(save), .restore(restore),
    .cwp_we(cwp_we), .cwp_wdata(cwp_wdata),
    .wim_we(wim_we), .wim_wdata(wim_wdata),
    .cwp(cwp), .wim(wim),
    .win_ovf(win_ovf), .win_unf(win_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Physical slot of a windowed logical register: window w holds outs at
  // 16w+0..7 and locals at 16w+8..15; ins are the outs of window w+1.
  function automatic int phys_of(input int r, input int w);
    if (r >= 24) return 16 * ((w + 1) % NW) + (r - 24);
    return 16 * w + (r - 8);
  endfunction

  function automatic logic [DW-1:0] m_read(input int r);
    if (r == 0) return '0;
    if (r < 8)  return m_glob[r];
    return m_phys[phys_of(r, m_cwp)];
  endfunction

  task automatic model_reset();
    m_cwp = 0; m_wim = '0; m_ovf = 0; m_unf = 0;
    for (int i = 0; i < 8; i++)   m_glob[i] = '0;
    for (int i = 0; i < NPH; i++) m_phys[i] = '0;
  endtask

  task automatic model_update();
    int nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (wr_en && wr_addr != 0) begin
      if (wr_addr < 8) m_glob[wr_addr] = wr_data;
      else             m_phys[phys_of(int'(wr_addr), m_cwp)] = wr_data;
    end
    m_ovf = 0;
    m_unf = 0;
    if (cwp_we) begin
      m_cwp = int'(cwp_wdata) % NW;
    end else if (save && !restore) begin
      nxt = (m_cwp + NW - 1) % NW;
      if (m_wim[nxt]) m_ovf = 1; else m_cwp = nxt;
    end else if (restore && !save) begin
      nxt = (m_cwp + 1) % NW;
      if (m_wim[nxt]) m_unf = 1; else m_cwp = nxt;
    end
    if (wim_we) m_wim = wim_wdata;
  endtask

  task automatic idle();
    wr_en = 0; save = 0; restore = 0; cwp_we = 0; wim_we = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    chk("pa",      pa,            m_read(int'(rd_a_addr)));
    chk("pb",      pb,            m_read(int'(rd_b_addr)));
    chk("cwp",     32'(cwp),      32'(m_cwp));
    chk("wim",     32'(wim),      32'(m_wim));
    chk("win_ovf", 32'(win_ovf),  32'(m_ovf));
    chk("win_unf", 32'(win_unf),  32'(m_unf));
  end

  initial begin
    rst_n = 0;
    idle();
    wr_addr = 0; wr_data = 0; rd_a_addr = 0; rd_b_addr = 0;
    cwp_wdata = 0; wim_wdata = 0;
    model_reset();
    @(negedge clk);
    chk("reset_cwp", 32'(cwp), 32'd0);
    chk("reset_wim", 32'(wim), 32'd0);
    #2 rst_n = 1;

    // r0 is hardwired zero
    step(); wr_en = 1; wr_addr = 0; wr_data = 32'hDEADBEEF;
    step(); idle(); rd_a_addr = 0;
    @(negedge clk); chk("r0_read", pa, 32'h0);

    // window overlap: outs of cwp=3 become ins of cwp=2
    step(); cwp_we = 1; cwp_wdata = 3;
    step(); idle(); wr_en = 1; wr_addr = 9; wr_data = 32'h11;
    step(); idle(); save = 1;
    step(); idle(); rd_a_addr = 25; rd_b_addr = 9;
    @(negedge clk);
    chk("overlap_cwp", 32'(cwp), 32'd2);
    chk("overlap_r25", pa, 32'h11);

    // overflow: wim bit 2 blocks save from window 3
    step(); cwp_we = 1; cwp_wdata = 3; wim_we = 1; wim_wdata = 8'h04;
    step(); idle(); save = 1;
    step(); idle();
    @(negedge clk);
    chk("ovf_cwp", 32'(cwp), 32'd3);
    chk("ovf_pulse", 32'(win_ovf), 32'd1);
    step();
    @(negedge clk); chk("ovf_clear", 32'(win_ovf), 32'd0);

    // wrap 7 -> 0, then underflow against wim bit 1
    step(); cwp_we = 1; cwp_wdata = 7; wim_we = 1; wim_wdata = 8'h00;
    step(); idle(); restore = 1;
    step(); idle();
    @(negedge clk); chk("wrap_cwp", 32'(cwp), 32'd0);
    step(); wim_we = 1; wim_wdata = 8'h02;
    step(); idle(); restore = 1;
    step(); idle();
    @(negedge clk);
    chk("unf_pulse", 32'(win_unf), 32'd1);
    chk("unf_cwp", 32'(cwp), 32'd0);
    step();
    @(negedge clk); chk("unf_clear", 32'(win_unf), 32'd0);

    // cwp_we beats save
    step(); cwp_we = 1; cwp_wdata = 5; save = 1;
    step(); idle();
    @(negedge clk);
    chk("prio_cwp", 32'(cwp), 32'd5);
    chk("prio_ovf", 32'(win_ovf), 32'd0);

    // simultaneous save+restore is a no-op
    step(); save = 1; restore = 1;
    step(); idle();
    @(negedge clk);
    chk("both_cwp", 32'(cwp), 32'd5);
    chk("both_unf", 32'(win_unf), 32'd0);

    // cwp_wdata beyond NWIN wraps modulo
    step(); cwp_we = 1; cwp_wdata = 5'd13;
    step(); idle();
    @(negedge clk); chk("cwp_mod", 32'(cwp), 32'd5);

    // asynchronous reset clears registers without a clock edge
    step(); wr_en = 1; wr_addr = 16; wr_data = 32'h55;
    step(); idle(); rd_a_addr = 16;
    @(negedge clk); chk("pre_reset_r16", pa, 32'h55);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("async_pa", pa, 32'h0);
    chk("async_cwp", 32'(cwp), 32'd0);
    step();
    #2 rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step();
      wr_en     = ($urandom_range(1, 0) == 1);
      wr_addr   = 5'($urandom_range(31, 0));
      wr_data   = $urandom;
      rd_a_addr = 5'($urandom_range(31, 0));
      rd_b_addr = 5'($urandom_range(31, 0));
      save      = ($urandom_range(4, 0) == 0);
      restore   = ($urandom_range(4, 0) == 0);
      cwp_we    = ($urandom_range(19, 0) == 0);
      cwp_wdata = 5'($urandom_range(31, 0));
      wim_we    = ($urandom_range(9, 0) == 0);
      wim_wdata = NW'($urandom_range(255, 0) & $urandom_range(255, 0));
      if (i == 1000) begin
        save = 1; wr_en = 1;
        #2 rst_n = 0;
        model_reset();
      end
      if (i == 1001) #2 rst_n = 1;
    end

    step(); idle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
